eth_rx_frame_buf: RTL

Sits directly downstream of the MAC receive path and consumes its byte stream (rx_vld/rx_dat/rx_sof/rx_eof/rx_err, no backpressure).
Buffers each frame in a circular RAM, checks CRC-32, length and error flags, then commits or rolls back the frame.
Good frames are replayed with the FCS stripped on a valid/ready byte stream toward the packet consumer; bad frames never appear at the output.
Saturating drop/accept counters are exported for status.

---
 rtl/eth_pkg.sv | 23 ++
 rtl/eth_rx_frame_buf_if.sv | 13 +
 rtl/eth_crc32.sv | 32 +++
 rtl/eth_rx_frame_buf.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared constants, CRC-32 byte step and enums for the Ethernet receive frame buffer
package eth_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
  localparam int          ETH_MIN_LEN   = 64;
  localparam int          ETH_MAX_LEN   = 1518;
  localparam int          LEN_W         = 11;

  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_DROP} rx_state_e;
  typedef enum logic [1:0] {DR_NONE, DR_OVF, DR_LEN, DR_CRC} drop_reason_e;

  // Reflected CRC-32, one byte per call, LSB of the byte first.
  function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] dat);
    logic [31:0] c;
    c = crc ^ {24'd0, dat};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_rx_frame_buf_if.sv
// rtl/eth_rx_frame_buf_if.sv - valid/ready byte stream from the frame buffer toward the packet consumer
interface eth_rx_frame_buf_if;

  logic       out_vld;
  logic [7:0] out_dat;
  logic       out_sof;
  logic       out_eof;
  logic       out_rdy;

  modport master (output out_vld, out_dat, out_sof, out_eof, input out_rdy);
  modport slave  (input out_vld, out_dat, out_sof, out_eof, output out_rdy);

endinterface

// File: rtl/eth_crc32.sv
// rtl/eth_crc32.sv - byte-serial CRC-32 register; residue_ok reflects the value after the current byte
module eth_crc32
  import eth_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       en,
  input  logic [7:0] dat,
  output logic       residue_ok
);

  logic [31:0] crc;
  logic [31:0] crc_nxt;

  // init and en together fold the first byte of a frame onto a fresh seed.
  always_comb begin
    crc_nxt    = crc32_next(init ? 32'hFFFF_FFFF : crc, dat);
    residue_ok = (crc_nxt == CRC32_RESIDUE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc <= 32'hFFFF_FFFF;
    end else if (en) begin
      crc <= crc_nxt;
    end else if (init) begin
      crc <= 32'hFFFF_FFFF;
    end
  end

endmodule

// File: rtl/eth_rx_frame_buf.sv
// rtl/eth_rx_frame_buf.sv - MAC receive frame buffer: store, CRC/length check, commit or roll back, replay
module eth_rx_frame_buf
  import eth_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int DESC_W  = 4,
  parameter int MAX_LEN = ETH_MAX_LEN,
  parameter int MIN_LEN = ETH_MIN_LEN
) (
  input  logic               clk_mac,
  input  logic               rst,
  input  logic               rx_vld,
  input  logic [7:0]         rx_dat,
  input  logic               rx_sof,
  input  logic               rx_eof,
  input  logic               rx_err,
  eth_rx_frame_buf_if.master pkt,
  output logic [15:0]        stat_good,
  output logic [15:0]        stat_crc,
  output logic [15:0]        stat_len,
  output logic [15:0]        stat_ovf
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PTR_W = ADDR_W + 1;
  localparam int NDESC = 1 << DESC_W;

  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [LEN_W-1:0]  len_t;
  typedef logic [DESC_W:0]   dptr_t;

  rx_state_e    state;
  drop_reason_e reason;
  ptr_t         wr_ptr, commit_ptr, rd_ptr;
  len_t         frame_len;
  logic         poison;

  logic [7:0]   ram [DEPTH];
  len_t         desc_mem [NDESC];
  dptr_t        desc_wr, desc_rd;
  len_t         desc_head, remaining;
  logic         desc_full, desc_empty;

  logic         start, open_byte, ram_full, len_full, do_write, crc_ok, push, pop, rd_go;
  ptr_t         base_ptr;
  len_t         base_len, len_incl;
  logic         base_poison;
  logic         inc_good, inc_crc, inc_len;
  logic [1:0]   inc_ovf;

  function automatic logic [15:0] sat_add(input logic [15:0] v, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, v} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  eth_crc32 u_crc (
    .clk        (clk_mac),
    .rst        (rst),
    .init       (start),
    .en         (do_write),
    .dat        (rx_dat),
    .residue_ok (crc_ok)
  );

  assign desc_full  = (desc_wr - desc_rd) == dptr_t'(NDESC);
  assign desc_empty = (desc_wr == desc_rd);
  assign desc_head  = desc_mem[desc_rd[DESC_W-1:0]];

  // A start-of-frame byte is evaluated against the committed pointer, whatever state we are in.
  always_comb begin
    start       = rx_vld && rx_sof;
    open_byte   = start || (rx_vld && state == ST_RECV);
    base_ptr    = start ? commit_ptr : wr_ptr;
    base_len    = start ? '0 : frame_len;
    base_poison = !start && poison;
    ram_full    = (base_ptr - rd_ptr) == ptr_t'(DEPTH);
    len_full    = (base_len == len_t'(MAX_LEN));
    do_write    = open_byte && !ram_full && !len_full;
    len_incl    = base_len + len_t'(1);
    push        = 1'b0;
    inc_good    = 1'b0;
    inc_crc     = 1'b0;
    inc_len     = 1'b0;
    inc_ovf     = 2'd0;
    if (start && state == ST_RECV) inc_ovf = 2'd1;
    if (rx_vld && rx_eof) begin
      if (open_byte && !do_write) begin
        if (ram_full) inc_ovf = inc_ovf + 2'd1;
        else          inc_len = 1'b1;
      end else if (do_write) begin
        if (len_incl < len_t'(MIN_LEN))   inc_len = 1'b1;
        else if (base_poison || rx_err)   inc_ovf = inc_ovf + 2'd1;
        else if (!crc_ok)                 inc_crc = 1'b1;
        else if (desc_full)               inc_ovf = inc_ovf + 2'd1;
        else begin
          push     = 1'b1;
          inc_good = 1'b1;
        end
      end else if (state == ST_DROP) begin
        if (reason == DR_OVF) inc_ovf = 2'd1;
        else                  inc_len = 1'b1;
      end
    end
  end

  always_comb begin
    rd_go = (!pkt.out_vld || pkt.out_rdy) && (remaining != '0 || !desc_empty);
    pop   = rd_go && (remaining == '0);
  end

  always_ff @(posedge clk_mac) begin
    if (do_write) ram[base_ptr[ADDR_W-1:0]] <= rx_dat;
    if (push)     desc_mem[desc_wr[DESC_W-1:0]] <= len_incl - len_t'(4);
  end

  always_ff @(posedge clk_mac) begin
    if (rst) begin
      state      <= ST_IDLE;
      reason     <= DR_NONE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      frame_len  <= '0;
      poison     <= 1'b0;
      desc_wr    <= '0;
      stat_good  <= '0;
      stat_crc   <= '0;
      stat_len   <= '0;
      stat_ovf   <= '0;
    end else begin
      if (open_byte) begin
        if (!do_write) begin
          state  <= rx_eof ? ST_IDLE : ST_DROP;
          reason <= ram_full ? DR_OVF : DR_LEN;
          wr_ptr <= base_ptr;
        end else begin
          state     <= rx_eof ? ST_IDLE : ST_RECV;
          wr_ptr    <= base_ptr + ptr_t'(1);
          frame_len <= len_incl;
          poison    <= base_poison || rx_err;
        end
      end else if (state == ST_RECV) begin
        if (rx_err) poison <= 1'b1;
      end else if (state == ST_DROP && rx_vld && rx_eof) begin
        state <= ST_IDLE;
      end
      // The FCS is released with the commit, so the next frame starts right after the payload.
      if (push) begin
        commit_ptr <= base_ptr + ptr_t'(1) - ptr_t'(4);
        desc_wr    <= desc_wr + dptr_t'(1);
      end
      stat_good <= sat_add(stat_good, {1'b0, inc_good});
      stat_crc  <= sat_add(stat_crc,  {1'b0, inc_crc});
      stat_len  <= sat_add(stat_len,  {1'b0, inc_len});
      stat_ovf  <= sat_add(stat_ovf,  inc_ovf);
    end
  end

  // The RAM read register is the output byte itself, so it only loads when the slot is free.
  always_ff @(posedge clk_mac) begin
    if (rst) begin
      rd_ptr      <= '0;
      desc_rd     <= '0;
      remaining   <= '0;
      pkt.out_vld <= 1'b0;
      pkt.out_dat <= '0;
      pkt.out_sof <= 1'b0;
      pkt.out_eof <= 1'b0;
    end else if (rd_go) begin
      pkt.out_vld <= 1'b1;
      pkt.out_dat <= ram[rd_ptr[ADDR_W-1:0]];
      rd_ptr      <= rd_ptr + ptr_t'(1);
      if (pop) begin
        remaining   <= desc_head - len_t'(1);
        pkt.out_sof <= 1'b1;
        pkt.out_eof <= (desc_head == len_t'(1));
        desc_rd     <= desc_rd + dptr_t'(1);
      end else begin
        remaining   <= remaining - len_t'(1);
        pkt.out_sof <= 1'b0;
        pkt.out_eof <= (remaining == len_t'(1));
      end
    end else if (pkt.out_rdy) begin
      pkt.out_vld <= 1'b0;
    end
  end

endmodule
